// File: rtl/iter_shifter_if.sv
// rtl/iter_shifter_if.sv - request/result bundle between the sequencer and the shift unit
interface iter_shifter_if #(
    parameter int WIDTH = 32
);
    localparam int SHW = $clog2(WIDTH);

    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] data_in;
    logic [SHW-1:0]   shamt;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             carry;

    modport master (
        output start, op, data_in, shamt,
        input  busy, done, result, carry
    );

    modport slave (
        input  start, op, data_in, shamt,
        output busy, done, result, carry
    );
endinterface

// File: rtl/iter_shifter.sv
// rtl/iter_shifter.sv - multi-cycle SHR/SHRA/SHL/ROR/ROL unit shifting up to STEP bits per clock
module iter_shifter #(
    parameter int WIDTH = 32,
    parameter int STEP  = 1
) (
    input  logic          clk_i,
    input  logic          clear_i,
    iter_shifter_if.slave bus
);
    localparam int SHW = $clog2(WIDTH);

    localparam logic [2:0] OP_SHR  = 3'b000;
    localparam logic [2:0] OP_SHRA = 3'b001;
    localparam logic [2:0] OP_SHL  = 3'b010;
    localparam logic [2:0] OP_ROR  = 3'b011;
    localparam logic [2:0] OP_ROL  = 3'b100;

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

    state_t           state_q;
    logic [WIDTH-1:0] acc_q;
    logic [SHW-1:0]   rem_q;
    logic [2:0]       op_q;
    logic [WIDTH-1:0] result_q;
    logic             carry_q;
    logic             busy_q;
    logic             done_q;

    logic [SHW-1:0]   k_d;
    logic [SHW-1:0]   wrap_d;
    logic [WIDTH-1:0] acc_d;
    logic             carry_d;

    // rem_q never reaches WIDTH, so the STEP constant only matters when it fits in SHW bits.
    always_comb begin
        k_d     = (int'(rem_q) < STEP) ? rem_q : SHW'(STEP);
        wrap_d  = ~k_d + SHW'(1);
        acc_d   = acc_q;
        carry_d = 1'b0;
        case (op_q)
            OP_SHR: begin
                acc_d   = acc_q >> k_d;
                carry_d = acc_q[k_d - SHW'(1)];
            end
            OP_SHRA: begin
                acc_d   = $signed(acc_q) >>> k_d;
                carry_d = acc_q[k_d - SHW'(1)];
            end
            OP_SHL: begin
                acc_d   = acc_q << k_d;
                carry_d = acc_q[wrap_d];
            end
            OP_ROR: begin
                acc_d   = (acc_q >> k_d) | (acc_q << wrap_d);
                carry_d = acc_d[WIDTH-1];
            end
            OP_ROL: begin
                acc_d   = (acc_q << k_d) | (acc_q >> wrap_d);
                carry_d = acc_d[0];
            end
            default: begin
                acc_d   = acc_q;
                carry_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge clear_i) begin
        if (!clear_i) begin
            state_q  <= S_IDLE;
            acc_q    <= '0;
            rem_q    <= '0;
            op_q     <= '0;
            result_q <= '0;
            carry_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.start) begin
                        acc_q  <= bus.data_in;
                        rem_q  <= bus.shamt;
                        op_q   <= bus.op;
                        busy_q <= 1'b1;
                        // Zero shifts and reserved ops complete as a pass-through.
                        if (bus.shamt == '0 || bus.op > OP_ROL) begin
                            result_q <= bus.data_in;
                            carry_q  <= 1'b0;
                            done_q   <= 1'b1;
                            state_q  <= S_DONE;
                        end else begin
                            state_q  <= S_SHIFT;
                        end
                    end
                end
                S_SHIFT: begin
                    acc_q <= acc_d;
                    rem_q <= rem_q - k_d;
                    if (rem_q == k_d) begin
                        result_q <= acc_d;
                        carry_q  <= carry_d;
                        done_q   <= 1'b1;
                        state_q  <= S_DONE;
                    end
                end
                S_DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.result = result_q;
    assign bus.carry  = carry_q;
endmodule

// File: tb/tb_iter_shifter.sv
// tb/tb_iter_shifter.sv - directed-vector bench for iter_shifter at STEP=1 and STEP=4
module tb_iter_shifter;
    logic        clk = 1'b0;
    logic        clear = 1'b0;
    logic        use4 = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  op = '0;
    logic [31:0] din = '0;
    logic [4:0]  sh = '0;
    int          n_tests = 0;
    int          n_fail = 0;

    iter_shifter_if #(.WIDTH(32)) a ();
    iter_shifter_if #(.WIDTH(32)) b ();

    assign a.start = start && !use4;
    assign b.start = start && use4;
    assign a.op = op;
    assign b.op = op;
    assign a.data_in = din;
    assign b.data_in = din;
    assign a.shamt = sh;
    assign b.shamt = sh;

    iter_shifter #(.WIDTH(32), .STEP(1)) dut1 (.clk_i(clk), .clear_i(clear), .bus(a));
    iter_shifter #(.WIDTH(32), .STEP(4)) dut4 (.clk_i(clk), .clear_i(clear), .bus(b));

    wire        s_busy   = use4 ? b.busy   : a.busy;
    wire        s_done   = use4 ? b.done   : a.done;
    wire [31:0] s_result = use4 ? b.result : a.result;
    wire        s_carry  = use4 ? b.carry  : a.carry;

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic launch(input logic [2:0] o, input logic [31:0] d, input logic [4:0] n);
        @(negedge clk);
        start = 1'b1; op = o; din = d; sh = n;
        @(posedge clk);
        #1 start = 1'b0; op = 3'b111; din = 32'h5555_AAAA; sh = 5'd13;
    endtask

    task automatic run(input string tag, input logic [2:0] o, input logic [31:0] d, input logic [4:0] n,
                       input int exp_c, input logic [31:0] exp_r, input logic exp_cy);
        int edges;
        launch(o, d, n);
        check({tag, " busy"}, 32'(s_busy), 32'd1);
        edges = 0;
        while (!s_done && edges < 100) begin
            @(posedge clk); #1;
            edges++;
        end
        check({tag, " edges"}, 32'(edges), 32'(exp_c));
        check({tag, " result"}, s_result, exp_r);
        check({tag, " carry"}, 32'(s_carry), 32'(exp_cy));
        @(posedge clk); #1;
        check({tag, " done falls"}, 32'(s_done), 32'd0);
        check({tag, " idle"}, 32'(s_busy), 32'd0);
        check({tag, " hold"}, s_result, exp_r);
    endtask

    initial begin
        int cnt;
        #12;
        check("reset busy", 32'(a.busy), 32'd0);
        check("reset done", 32'(a.done), 32'd0);
        check("reset result", a.result, 32'd0);
        check("reset carry", 32'(a.carry), 32'd0);
        @(negedge clk); clear = 1'b1;

        run("shra7",  3'b001, 32'h80A0_0044, 5'd7,  7,  32'hFF01_4000, 1'b1);
        run("shr7",   3'b000, 32'h80A0_0044, 5'd7,  7,  32'h0101_4000, 1'b1);
        run("shl31",  3'b010, 32'h0000_0001, 5'd31, 31, 32'h8000_0000, 1'b0);
        run("ror4",   3'b011, 32'h0000_0001, 5'd4,  4,  32'h1000_0000, 1'b0);
        run("rol1",   3'b100, 32'h8000_0001, 5'd1,  1,  32'h0000_0003, 1'b1);
        run("rol8",   3'b100, 32'h1234_5678, 5'd8,  8,  32'h3456_7812, 1'b0);
        run("ror8",   3'b011, 32'h1234_5678, 5'd8,  8,  32'h7812_3456, 1'b0);
        run("shr31",  3'b000, 32'hF000_0000, 5'd31, 31, 32'h0000_0001, 1'b1);
        run("n0",     3'b001, 32'hDEAD_BEEF, 5'd0,  0,  32'hDEAD_BEEF, 1'b0);
        run("rsvd",   3'b101, 32'hDEAD_BEEF, 5'd9,  0,  32'hDEAD_BEEF, 1'b0);

        // A second start while busy must not queue or restart anything.
        launch(3'b001, 32'h80A0_0044, 5'd7);
        cnt = 0;
        for (int i = 0; i < 15; i++) begin
            if (i == 3) begin
                @(negedge clk); start = 1'b1; op = 3'b101; din = 32'hDEAD_BEEF; sh = 5'd0;
            end
            @(posedge clk); #1;
            start = 1'b0;
            if (s_done) cnt++;
        end
        check("ignore dones", 32'(cnt), 32'd1);
        check("ignore result", s_result, 32'hFF01_4000);

        use4 = 1'b1;
        run("s4 shra7", 3'b001, 32'h80A0_0044, 5'd7, 2, 32'hFF01_4000, 1'b1);
        run("s4 rol5",  3'b100, 32'h8000_0001, 5'd5, 2, 32'h0000_0030, 1'b0);
        run("s4 shl4",  3'b010, 32'h0000_00F1, 5'd4, 1, 32'h0000_0F10, 1'b0);
        use4 = 1'b0;

        launch(3'b001, 32'h80A0_0044, 5'd7);
        repeat (3) @(posedge clk);
        #2 clear = 1'b0;
        #1;
        check("rst busy", 32'(a.busy), 32'd0);
        check("rst result", a.result, 32'd0);
        check("rst carry", 32'(a.carry), 32'd0);
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (a.done) cnt++;
        end
        check("rst no done", 32'(cnt), 32'd0);
        @(negedge clk); clear = 1'b1;
        run("post rst shl1", 3'b010, 32'h0000_0001, 5'd1, 1, 32'h0000_0002, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end
endmodule

// File: doc/iter_shifter.md
Name: iter_shifter

Overview:
- Parametrised multi-cycle shift/rotate unit for the DataPath ALU. Executes SHR, SHRA, SHL, ROR and ROL over a configurable word width, shifting up to STEP bits per clock.
- Replaces the single-mode, fixed-32-bit shra path. Adds a start/busy/done handshake so the control sequencer can hold in T4 until the result is valid, then move the result to Z.

Parameters:
- WIDTH, 32, data width in bits; power of 2, at least 2.
- STEP, 1, maximum bits shifted per cycle; power of 2, 1 <= STEP <= WIDTH.
- SHW (localparam), $clog2(WIDTH), shift-amount width.

Ports:
- Clock  in  1  system clock; all state changes on the rising edge.
- clear  in  1  asynchronous, active-low reset.
- start  in  1  request; sampled only in IDLE.
- op  in  3  000 SHR, 001 SHRA, 010 SHL, 011 ROR, 100 ROL; 101-111 reserved.
- data_in  in  WIDTH  operand; captured on the accepting edge.
- shamt  in  SHW  shift amount n; captured on the accepting edge.
- busy  out  1  high whenever the state is not IDLE.
- done  out  1  one-cycle completion pulse.
- result  out  WIDTH  registered result; holds until the next completion.
- carry  out  1  registered last bit shifted out (see Behaviour).

Behaviour:
- Reset (clear=0, asynchronous): state=IDLE; busy=0, done=0, result=0, carry=0.
  - Internal accumulator and counter clear to 0.
  - Takes effect mid-operation with no done pulse. The operation is lost.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - On an edge with start=1, capture acc<=data_in, rem<=shamt, op_r<=op.
  - Go to SHIFT if shamt!=0, else DONE.
  - Otherwise stay in IDLE.
- SHIFT, each edge:
  - k = min(STEP, rem).
  - acc <= acc shifted/rotated by k per op_r; rem <= rem-k.
  - SHR fills with 0; SHRA fills with acc[WIDTH-1] (the original sign); SHL fills LSBs with 0.
  - ROR/ROL wrap bits around.
  - If rem-k==0: go to DONE, registering result<=new acc and carry.
- carry rules:
  - SHR/SHRA: original bit n-1.
  - SHL: original bit WIDTH-n.
  - ROR: result[WIDTH-1].
  - ROL: result[0].
  - n=0: result=data_in, carry=0.
- Reserved op: treated as n=0, so result=data_in and carry=0, whatever shamt is.
- DONE: done=1 for exactly one cycle; next edge returns to IDLE unconditionally.
- Latency:
  - Accepting edge is edge 0; C = ceil(n/STEP).
  - done is high in the cycle after edge C; result and carry are valid from that same cycle.
  - Throughput: one operation per C+2 cycles.
- start while busy (SHIFT or DONE) is ignored; no queuing.
- data_in, shamt and op may change freely after the accepting edge.
- result and carry hold their values after done falls, until the next operation reaches DONE.
- The shift amount is inherently modulo WIDTH because shamt is SHW bits; no shift by >= WIDTH is possible.
- No combinational path from any input to any output.

Test Plan:
- WIDTH=32, STEP=1; SHRA, data_in=0x80A00044, n=7, start at edge 0.
  - busy high from edges 0-8; done only in the cycle after edge 7.
  - result=0xFF014000, carry=1.
- Same operands with SHR -> result=0x01014000, carry=1. SHL 0x00000001, n=31 -> result=0x80000000, carry=0.
- ROR 0x00000001, n=4 -> result=0x10000000, carry=0. ROL 0x80000001, n=1 -> result=0x00000003, carry=1.
- n=0 or op=101 with data_in=0xDEADBEEF:
  - done in the cycle after edge 0; result=0xDEADBEEF, carry=0.
  - A start pulse while busy from a prior n=7 job is ignored: one done only, result from the first job.
- STEP=4 instance; SHRA 0x80A00044, n=7 -> done in the cycle after edge 2 (C=2), result=0xFF014000.
- Mid-operation reset: clear low at edge 3 of an n=7 job, between edges, asynchronously.
  - busy, result and carry go to 0 immediately; no done pulse.
  - After release, a new SHL 0x1, n=1 job completes normally with result=0x00000002.
